class_argmax: RTL and testbench

CLASS_ARGMAX -- requirements
Module: class_argmax

---
 rtl/cnn_pkg.sv | 14 +
 rtl/class_argmax.sv | 182 ++++++++++++++++++
 tb/tb_class_argmax.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN constants and the argmax-stage FSM state type.
package cnn_pkg;

    localparam int unsigned CNN_DATA_WIDTH  = 16;
    localparam int unsigned CNN_NUM_CLASSES = 64;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrop,
        StReport
    } e_argmax_state;

endpackage

// File: rtl/class_argmax.sv
// Streaming argmax over one frame of signed class scores; reports the winning index,
// its score, the margin to the runner-up and a frame-length error flag.
module class_argmax
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = CNN_DATA_WIDTH,
    parameter int unsigned NUM_CLASSES = CNN_NUM_CLASSES,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_sop,
    input  logic                  i_eop,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [IDX_WIDTH-1:0]  o_class,
    output logic [DATA_WIDTH-1:0] o_max,
    output logic [DATA_WIDTH:0]   o_margin,
    output logic                  o_err
);

    localparam int unsigned CNT_WIDTH = $clog2(NUM_CLASSES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(NUM_CLASSES);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    e_argmax_state state_q, state_d;

    logic signed [DATA_WIDTH-1:0] best_q, best_d, second_q, second_d;
    logic [IDX_WIDTH-1:0]         idx_q, idx_d;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

    logic                         valid_q, valid_d, ready_q, ready_d, err_q, err_d;
    logic [IDX_WIDTH-1:0]         class_q, class_d;
    logic signed [DATA_WIDTH-1:0] max_q, max_d;
    logic [DATA_WIDTH:0]          margin_q, margin_d;

    logic                         accept, full, report, rep_err;
    logic signed [DATA_WIDTH-1:0] score, upd_best, upd_second, rep_best, rep_second;
    logic [IDX_WIDTH-1:0]         upd_idx, rep_idx;

    assign score  = $signed(i_data);
    assign accept = i_valid && ready_q && clk_en;
    assign full   = (cnt_q == CNT_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept && i_sop) state_d = i_eop ? StReport : StScan;
            end
            StScan: begin
                if (accept) begin
                    if (i_eop)      state_d = StReport;
                    else if (i_sop) state_d = StScan;
                    else if (full)  state_d = StDrop;
                end
            end
            StDrop: begin
                if (accept) begin
                    if (i_eop)      state_d = StReport;
                    else if (i_sop) state_d = StScan;
                end
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Strictly-greater compare keeps the lowest index on ties; a tie lands in second.
    always_comb begin
        upd_best   = best_q;
        upd_second = second_q;
        upd_idx    = idx_q;
        if (score > best_q) begin
            upd_best   = score;
            upd_second = best_q;
            upd_idx    = IDX_WIDTH'(cnt_q);
        end else if (score > second_q) begin
            upd_second = score;
        end
    end

    always_comb begin
        best_d     = best_q;
        second_d   = second_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        report     = 1'b0;
        rep_best   = best_q;
        rep_second = second_q;
        rep_idx    = idx_q;
        rep_err    = 1'b1;
        // ready_q is low in StReport, so an accepted sop always (re)starts a frame.
        if (accept && i_sop) begin
            best_d   = score;
            second_d = MOST_NEG;
            idx_d    = '0;
            cnt_d    = CNT_WIDTH'(1);
            if (i_eop) begin
                report     = 1'b1;
                rep_best   = score;
                rep_second = score;
                rep_idx    = '0;
            end
        end else if (accept && state_q == StScan) begin
            if (!full) begin
                best_d     = upd_best;
                second_d   = upd_second;
                idx_d      = upd_idx;
                cnt_d      = cnt_q + CNT_WIDTH'(1);
                rep_best   = upd_best;
                rep_second = upd_second;
                rep_idx    = upd_idx;
                rep_err    = (cnt_q + CNT_WIDTH'(1)) != CNT_FULL;
            end
            report = i_eop;
        end else if (accept && state_q == StDrop) begin
            report = i_eop;
        end
    end

    always_comb begin
        valid_d  = report;
        ready_d  = (state_d != StReport);
        class_d  = class_q;
        max_d    = max_q;
        margin_d = margin_q;
        err_d    = err_q;
        if (report) begin
            class_d  = rep_idx;
            max_d    = rep_best;
            margin_d = {rep_best[DATA_WIDTH-1], rep_best}
                     - {rep_second[DATA_WIDTH-1], rep_second};
            err_d    = rep_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q   <= '0;
            second_q <= MOST_NEG;
            idx_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            class_q  <= '0;
            max_q    <= '0;
            margin_q <= '0;
            err_q    <= 1'b0;
        end else if (clk_en) begin
            best_q   <= best_d;
            second_q <= second_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            class_q  <= class_d;
            max_q    <= max_d;
            margin_q <= margin_d;
            err_q    <= err_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_class  = class_q;
    assign o_max    = max_q;
    assign o_margin = margin_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_class_argmax.sv
// Directed and randomized frames for class_argmax, checked against a frame-level model.
module tb_class_argmax;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 4;
    localparam int unsigned IW = 2;

    typedef struct {
        logic [IW-1:0] cls;
        logic [DW-1:0] mx;
        logic [DW:0]   mg;
        logic          err;
    } res_t;

    logic          clk = 1'b0;
    logic          rst, clk_en, i_valid, i_sop, i_eop;
    logic [DW-1:0] i_data;
    logic          o_ready, o_valid, o_err;
    logic [IW-1:0] o_class;
    logic [DW-1:0] o_max;
    logic [DW:0]   o_margin;

    int   checks = 0;
    int   errors = 0;
    bit   rand_en = 1'b0;
    res_t got_q[$];

    class_argmax #(
        .DATA_WIDTH (DW),
        .NUM_CLASSES(NC),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_sop   (i_sop),
        .i_eop   (i_eop),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_class (o_class),
        .o_max   (o_max),
        .o_margin(o_margin),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    // One entry per enabled cycle with o_valid high.
    always @(negedge clk) begin
        if (rst === 1'b0 && o_valid === 1'b1 && clk_en === 1'b1)
            got_q.push_back('{o_class, o_max, o_margin, o_err});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        clk_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        clk_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic sop, input logic eop);
        bit done = 1'b0;
        i_data  = d;
        i_sop   = sop;
        i_eop   = eop;
        i_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            clk_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            done = clk_en && o_ready;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        chk("beat_accepted", 32'(done), 32'd1);
    endtask

    task automatic send_seq(input int q[$], input bit with_eop);
        for (int i = 0; i < q.size(); i++) begin
            int v = q[i];
            send_beat(v[DW-1:0], i == 0, with_eop && (i == q.size() - 1));
        end
        if (with_eop) begin
            chk("latency_valid", 32'(o_valid), 32'd1);
            chk("report_not_ready", 32'(o_ready), 32'd0);
        end
    endtask

    // Frame-level reference: argmax with lowest index on ties over the first NC scores.
    function automatic res_t model(input int q[$]);
        res_t r;
        int   n, bi, mx, sec;
        bit   found;
        n  = (q.size() < NC) ? q.size() : NC;
        bi = 0;
        for (int i = 1; i < n; i++) if (q[i] > q[bi]) bi = i;
        mx    = q[bi];
        sec   = mx;
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i != bi && (!found || q[i] > sec)) begin
                sec   = q[i];
                found = 1'b1;
            end
        end
        r.cls = bi[IW-1:0];
        r.mx  = mx[DW-1:0];
        r.mg  = 17'(mx - sec);
        r.err = (q.size() != NC);
        return r;
    endfunction

    task automatic check_frame(input string tag, input res_t e);
        flush();
        chk({tag, "_count"}, got_q.size(), 32'd1);
        if (got_q.size() > 0) begin
            chk({tag, "_class"}, 32'(got_q[0].cls), 32'(e.cls));
            chk({tag, "_max"}, 32'(got_q[0].mx), 32'(e.mx));
            chk({tag, "_margin"}, 32'(got_q[0].mg), 32'(e.mg));
            chk({tag, "_err"}, 32'(got_q[0].err), 32'(e.err));
        end
        got_q.delete();
        repeat (3) step();
        chk({tag, "_hold_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_hold_class"}, 32'(o_class), 32'(e.cls));
        chk({tag, "_hold_max"}, 32'(o_max), 32'(e.mx));
        chk({tag, "_hold_margin"}, 32'(o_margin), 32'(e.mg));
        chk({tag, "_hold_err"}, 32'(o_err), 32'(e.err));
    endtask

    task automatic run_frame(input string tag, input int q[$], input res_t e);
        send_seq(q, 1'b1);
        check_frame(tag, e);
    endtask

    initial begin
        rst     = 1'b1;
        clk_en  = 1'b0;
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        i_data  = '0;
        #1;
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_class", 32'(o_class), 32'd0);
        chk("reset_max", 32'(o_max), 32'd0);
        chk("reset_margin", 32'(o_margin), 32'd0);
        chk("reset_err", 32'(o_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        clk_en = 1'b1;
        step();
        chk("post_reset_ready", 32'(o_ready), 32'd1);

        for (int pass = 0; pass < 2; pass++) begin
            rand_en = (pass == 1);
            run_frame("basic", '{5, -3, 9, 2}, '{2'd2, 16'd9, 17'd4, 1'b0});
            run_frame("tie", '{7, 7, -1, 0}, '{2'd0, 16'd7, 17'd0, 1'b0});
            run_frame("short", '{-8, -2, -5}, '{2'd1, 16'(-2), 17'd3, 1'b1});
            run_frame("drop", '{1, 2, 3, 4, 50}, '{2'd3, 16'd4, 17'd1, 1'b1});
            run_frame("drop_long", '{1, 9, 3, 4, 99, 98, 97}, '{2'd1, 16'd9, 17'd5, 1'b1});
            send_seq('{1, 2}, 1'b0);
            run_frame("restart", '{0, 0, 6, 0}, '{2'd2, 16'd6, 17'd6, 1'b0});
            run_frame("single", '{-7}, '{2'd0, 16'(-7), 17'd0, 1'b1});
            run_frame("extreme", '{32767, -32768, -32768, -32768},
                      '{2'd0, 16'd32767, 17'd65535, 1'b0});
            run_frame("all_min", '{-32768, -32768, -32768, -32768},
                      '{2'd0, 16'h8000, 17'd0, 1'b0});

            // Reset mid-frame, then an eop-only beat that an idle block must ignore.
            send_seq('{9, 9}, 1'b0);
            rst = 1'b1;
            #1;
            chk("midrst_valid", 32'(o_valid), 32'd0);
            chk("midrst_class", 32'(o_class), 32'd0);
            chk("midrst_max", 32'(o_max), 32'd0);
            clk_en = 1'b0;
            @(negedge clk);
            @(posedge clk);
            #1;
            chk("midrst_valid_held", 32'(o_valid), 32'd0);
            rst = 1'b0;
            send_beat(16'd100, 1'b0, 1'b1);
            flush();
            chk("midrst_no_result", got_q.size(), 32'd0);
            got_q.delete();
            run_frame("after_rst", '{3, 1, 1, 1}, '{2'd0, 16'd3, 17'd2, 1'b0});

            for (int f = 0; f < 10; f++) begin
                int q[$];
                int len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++) begin
                    int v;
                    if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 65535)) - 32768;
                    else v = int'($urandom_range(0, 6)) - 3;
                    q.push_back(v);
                end
                run_frame("random", q, model(q));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
